// File: rtl/mdc_delay_commutator.sv
`default_nettype none
// ============================================================================
// Module   : mdc_delay_commutator
// Brief    : Radix-2 MDC stage interconnect (upper delay, commutator, lower
//            delay) with phase counter, priming, frame alignment and bypass.
// Revision : 1.0  initial release
// ============================================================================
module mdc_delay_commutator #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             bypass,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] up_in_re,
    input  logic [WIDTH-1:0] up_in_im,
    input  logic [WIDTH-1:0] low_in_re,
    input  logic [WIDTH-1:0] low_in_im,
    output logic [WIDTH-1:0] up_out_re,
    output logic [WIDTH-1:0] up_out_im,
    output logic [WIDTH-1:0] low_out_re,
    output logic [WIDTH-1:0] low_out_im,
    output logic             out_valid
);
    localparam int c_PHASE_W = $clog2(2*DEPTH);
    localparam int c_FILL_W  = $clog2(2*DEPTH+1);
    localparam int c_DW      = 2*WIDTH;
    localparam logic [c_FILL_W-1:0] c_FULL = c_FILL_W'(2*DEPTH);

    logic [c_PHASE_W-1:0] r_phase;
    logic [c_FILL_W-1:0]  r_fill;
    logic                 r_bypass_q;
    logic                 r_valid;
    logic [c_DW-1:0]      r_up;
    logic [c_DW-1:0]      r_low;
    logic [c_DW-1:0]      r_ud [DEPTH];
    logic [c_DW-1:0]      r_ld [DEPTH];

    logic                 w_clr;
    logic                 w_mdc_acc;
    logic                 w_primed;
    logic                 w_s;
    logic [c_PHASE_W-1:0] w_p;
    logic [c_DW-1:0]      w_u;
    logic [c_DW-1:0]      w_l;
    logic [c_DW-1:0]      w_ud;
    logic [c_DW-1:0]      w_ld;
    logic [c_DW-1:0]      w_x;
    logic [c_DW-1:0]      w_up;

    // A bypass level change flushes exactly like an explicit clear.
    assign w_clr     = clear | (bypass != r_bypass_q);
    assign w_mdc_acc = in_valid & ~w_clr & ~bypass;
    assign w_primed  = (r_fill == c_FULL);

    assign w_p  = in_sof ? '0 : r_phase;
    assign w_s  = w_p[c_PHASE_W-1];
    assign w_u  = {up_in_re, up_in_im};
    assign w_l  = {low_in_re, low_in_im};
    assign w_ud = r_ud[DEPTH-1];
    assign w_ld = r_ld[DEPTH-1];
    assign w_x  = w_s ? w_ud : w_l;
    assign w_up = w_s ? w_l : w_ud;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= '0;
            r_fill     <= '0;
            r_bypass_q <= 1'b0;
            r_valid    <= 1'b0;
            r_up       <= '0;
            r_low      <= '0;
        end else begin
            r_bypass_q <= bypass;
            if (w_clr) begin
                r_phase <= '0;
                r_fill  <= '0;
                r_valid <= 1'b0;
            end else if (in_valid && bypass) begin
                r_valid <= 1'b1;
                r_up    <= w_u;
                r_low   <= w_l;
            end else if (in_valid) begin
                r_phase <= w_p + c_PHASE_W'(1);
                r_valid <= w_primed;
                if (w_primed) begin
                    r_up  <= w_up;
                    r_low <= w_ld;
                end else begin
                    r_fill <= r_fill + c_FILL_W'(1);
                end
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    // Delay storage is never observable before priming, so it carries no reset.
    always_ff @(posedge clk) begin
        if (w_mdc_acc) begin
            r_ud[0] <= w_u;
            r_ld[0] <= w_x;
            for (int i = 1; i < DEPTH; i++) begin
                r_ud[i] <= r_ud[i-1];
                r_ld[i] <= r_ld[i-1];
            end
        end
    end

    assign up_out_re  = r_up[c_DW-1:WIDTH];
    assign up_out_im  = r_up[WIDTH-1:0];
    assign low_out_re = r_low[c_DW-1:WIDTH];
    assign low_out_im = r_low[WIDTH-1:0];
    assign out_valid  = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mdc_delay_commutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdc_delay_commutator
// Brief    : Self-checking bench for mdc_delay_commutator against a
//            sample-history reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mdc_delay_commutator;
    localparam int WIDTH = 9;
    localparam int DEPTH = 2;
    localparam int P2    = 2*DEPTH;
    localparam int DW    = 2*WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             bypass = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [WIDTH-1:0] up_in_re = '0;
    logic [WIDTH-1:0] up_in_im = '0;
    logic [WIDTH-1:0] low_in_re = '0;
    logic [WIDTH-1:0] low_in_im = '0;
    logic [WIDTH-1:0] up_out_re;
    logic [WIDTH-1:0] up_out_im;
    logic [WIDTH-1:0] low_out_re;
    logic [WIDTH-1:0] low_out_im;
    logic             out_valid;

    mdc_delay_commutator #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bypass(bypass),
        .in_valid(in_valid), .in_sof(in_sof),
        .up_in_re(up_in_re), .up_in_im(up_in_im),
        .low_in_re(low_in_re), .low_in_im(low_in_im),
        .up_out_re(up_out_re), .up_out_im(up_out_im),
        .low_out_re(low_out_re), .low_out_im(low_out_im),
        .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: every accepted MDC-mode sample's U and X, indexed by count.
    logic [DW-1:0] hu[$];
    logic [DW-1:0] hx[$];
    int            m_phase;
    int            m_fill;
    logic          m_prevbyp;
    logic          m_valid;
    logic [DW-1:0] m_up;
    logic [DW-1:0] m_low;
    logic          byp_r;

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'($urandom);
    endfunction

    task automatic model_reset();
        m_phase   = 0;
        m_fill    = 0;
        m_prevbyp = 1'b0;
        m_valid   = 1'b0;
        m_up      = '0;
        m_low     = '0;
    endtask

    task automatic check_outputs(input string tag);
        n_cmp++;
        assert (out_valid === m_valid) else begin
            n_err++;
            $error("FAIL %s out_valid: got %0b expected %0b", tag, out_valid, m_valid);
        end
        n_cmp++;
        assert ({up_out_re, up_out_im} === m_up) else begin
            n_err++;
            $error("FAIL %s up_out: got %h expected %h", tag, {up_out_re, up_out_im}, m_up);
        end
        n_cmp++;
        assert ({low_out_re, low_out_im} === m_low) else begin
            n_err++;
            $error("FAIL %s low_out: got %h expected %h", tag, {low_out_re, low_out_im}, m_low);
        end
    endtask

    task automatic check_re(input string tag, input logic [WIDTH-1:0] up_exp,
                            input logic [WIDTH-1:0] low_exp);
        n_cmp++;
        assert (up_out_re === up_exp && low_out_re === low_exp && out_valid === 1'b1) else begin
            n_err++;
            $error("FAIL %s pair: got (%0d,%0d,v=%0b) expected (%0d,%0d,v=1)", tag,
                   up_out_re, low_out_re, out_valid, up_exp, low_exp);
        end
    endtask

    task automatic step(input logic v, input logic sof, input logic clr, input logic byp,
                        input logic [DW-1:0] u, input logic [DW-1:0] l, input string tag);
        int            p;
        int            k;
        logic          s;
        logic          chg;
        logic [DW-1:0] ud;
        logic [DW-1:0] ld;
        logic [DW-1:0] x;
        in_valid = v;
        in_sof   = sof;
        clear    = clr;
        bypass   = byp;
        {up_in_re, up_in_im}   = u;
        {low_in_re, low_in_im} = l;

        chg       = (byp !== m_prevbyp);
        m_prevbyp = byp;
        if (clr || chg) begin
            m_phase = 0;
            m_fill  = 0;
            m_valid = 1'b0;
        end else if (!v) begin
            m_valid = 1'b0;
        end else if (byp) begin
            m_valid = 1'b1;
            m_up    = u;
            m_low   = l;
        end else begin
            p  = sof ? 0 : m_phase;
            s  = (p >= DEPTH);
            k  = hu.size();
            ud = (k >= DEPTH) ? hu[k-DEPTH] : '0;
            ld = (k >= DEPTH) ? hx[k-DEPTH] : '0;
            x  = s ? ud : l;
            hu.push_back(u);
            hx.push_back(x);
            m_valid = (m_fill == P2);
            if (m_valid) begin
                m_up  = s ? l : ud;
                m_low = ld;
            end
            if (m_fill < P2) m_fill++;
            m_phase = (p + 1) % P2;
        end

        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        rst_n = 1'b1;

        // Counting stream from n=0
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, {WIDTH'(i), rnd()}, {WIDTH'(100 + i), rnd()}, "stream");
            if (i == 4) check_re("stream_first", WIDTH'(2), WIDTH'(0));
            if (i == 5) check_re("stream_second", WIDTH'(3), WIDTH'(1));
            if (i == 6) check_re("stream_swap", WIDTH'(106), WIDTH'(104));
        end

        // Valid toggling: gaps must hold outputs
        for (int i = 12; i < 28; i++)
            step(i[0], 1'b0, 1'b0, 1'b0, {WIDTH'(i), rnd()}, {WIDTH'(100 + i), rnd()}, "gaps");

        // Frame realignment mid-stream
        for (int i = 0; i < 10; i++)
            step(1'b1, (i == 4), 1'b0, 1'b0, {rnd(), rnd()}, {rnd(), rnd()}, "sof");

        // Clear flushes priming
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b0, (i == 5), 1'b0, {rnd(), rnd()}, {rnd(), rnd()}, "clear");

        // Bypass extremes
        step(1'b1, 1'b0, 1'b0, 1'b1, {9'h100, rnd()}, {9'd7, rnd()}, "byp_enter");
        step(1'b1, 1'b0, 1'b0, 1'b1, {9'h100, rnd()}, {9'd7, rnd()}, "byp_neg");
        check_re("byp_neg_pair", 9'h100, 9'd7);
        step(1'b1, 1'b0, 1'b0, 1'b1, {9'h0FF, rnd()}, {9'd7, rnd()}, "byp_pos");
        check_re("byp_pos_pair", 9'h0FF, 9'd7);
        step(1'b0, 1'b0, 1'b0, 1'b1, {rnd(), rnd()}, {rnd(), rnd()}, "byp_idle");
        for (int i = 0; i < P2 + 4; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, {rnd(), rnd()}, {rnd(), rnd()}, "byp_exit");

        // Asynchronous reset mid-frame, away from any clock edge
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 1'b0, 1'b0, {rnd(), rnd()}, {rnd(), rnd()}, "pre_rst");
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        bypass   = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        @(posedge clk);
        #1;
        check_outputs("reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, {WIDTH'(i), rnd()}, {WIDTH'(100 + i), rnd()}, "post_rst");
            if (i == 4) check_re("post_rst_first", WIDTH'(2), WIDTH'(0));
            if (i == 7) check_re("post_rst_swap", WIDTH'(107), WIDTH'(105));
        end

        // Randomised traffic
        byp_r = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) byp_r = ~byp_r;
            step(($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 99) < 3), byp_r,
                 {rnd(), rnd()}, {rnd(), rnd()}, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
